sha256_compress: RTL and testbench
==================================

SHA256_COMPRESS -- requirements
Module: sha256_compress

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to compress one block; accepted only in IDLE.
REQ-005 The block SHALL have port first, input, 1 bit: sampled with an accepted start; 1 selects the IV as chaining value, 0 selects the current digest.
REQ-006 The block SHALL have port block, input, 512 bits: message block, with block[511:480] as W0 and block[31:0] as W15.
REQ-007 The block SHALL have port k_in, input, 32 bits: round constant from the external K ROM, combinationally valid for the current round_o.
REQ-008 The block SHALL have port round_o, output, 6 bits: current round index that drives the K ROM address.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a block is in flight.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when digest has been updated.
REQ-011 The block SHALL have port digest, output, 256 bits: chaining/result value, with digest[255:224] as H0 and digest[31:0] as H7.

Function
REQ-012 The FSM SHALL have states IDLE, ROUND and FINAL.
REQ-013 At edge E0, in IDLE with start=1, the block SHALL:
- capture block into a 16-word W window;
- load the working registers a..h and the chaining register H (from the IV if first=1, else from digest);
- clear the round counter;
- go to ROUND and set busy=1.
REQ-014 In ROUND, round_o SHALL equal the counter value.
REQ-015 Each edge in ROUND SHALL perform one FIPS 180-4 round using k_in and W[t], then increment the counter.
REQ-016 Edges E1..E64 SHALL execute rounds 0..63; the edge that executes round 63 SHALL move the FSM to FINAL.
REQ-017 For t≥16, W[t] SHALL be produced by a sliding window: new word = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], shifted in each round after round 0..15 words are consumed.
REQ-018 All additions SHALL be modulo 2^32, with no carry out.
REQ-019 At E65, in FINAL, the block SHALL set digest = H + {a..h} word-wise, done=1 for exactly one cycle, busy=0, and go to IDLE.
REQ-020 Latency from start edge to done high SHALL be 65 cycles; throughput SHALL be one block per 66 cycles.
REQ-021 start while busy=1 or in FINAL SHALL be ignored, with no state change.
REQ-022 start is legal in the cycle done is high, because the FSM is in IDLE; back-to-back blocks SHALL be allowed.
REQ-023 digest SHALL change only at FINAL or reset.
REQ-024 block and first SHALL be sampled only at E0; changes afterwards SHALL have no effect.
REQ-025 In IDLE and FINAL, round_o SHALL be held at 0.

Reset
REQ-026 rst=1 at any edge SHALL force IDLE with busy=0, done=0, round_o=0, digest=0, and a..h, H and W cleared.
REQ-027 rst SHALL take priority over start.
REQ-028 rst mid-block SHALL abort the block with no done pulse; a new start with first=1 is then required.

Configuration
REQ-029 When SHA224_EN is defined, the IV SHALL be the SHA-224 IV: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.
REQ-030 When SHA224_EN is defined, digest SHALL remain 256 bits, and the host SHALL take digest[255:32].
REQ-031 When SHA224_EN is undefined, the IV SHALL be the SHA-256 IV: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
REQ-032 Interface and timing SHALL be identical with and without SHA224_EN.

Verification
REQ-033 Scenario "abc", SHA-256 (K ROM attached): block=61626380 followed by 0s, last word 00000018, first=1 -> done at cycle 65 and digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-034 Scenario empty message: block=80000000 followed by 0s, first=1 -> digest=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-035 Scenario two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with first=1, then block 2 with first=0 started in the done cycle -> second done and digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-036 Scenario abort: assert rst at cycle 30 of a block -> next cycle busy=0, digest=0, and no done pulse within 70 cycles.
REQ-037 Scenario ignored start: pulse start at cycles 10 and 64 of a block -> exactly one done, and round_o sequence 0..63 uninterrupted.
REQ-038 Scenario SHA224_EN defined, "abc" block with first=1 -> digest[255:32]=23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7.

Source files
------------

// File: rtl/sha256_compress.sv
// SHA-256 compression core: one 64-round block per 66 cycles, K supplied
// by an external ROM addressed by round_o.
// Ports: clk, rst (sync, active-high), start, first, block[511:0],
//   k_in[31:0] in; round_o[5:0], busy, done, digest[255:0] out.
// Define SHA224_EN to load the SHA-224 IV instead of the SHA-256 IV.
module sha256_compress (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         first,
    input  logic [511:0] block,
    input  logic [31:0]  k_in,
    output logic [5:0]   round_o,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

`ifdef SHA224_EN
    localparam logic [255:0] IV = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
`else
    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
`endif

    state_t         r_state;
    state_t         w_next;
    logic [31:0]    r_w [16];
    logic [31:0]    r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
    logic [255:0]   r_hv;
    logic [255:0]   r_digest;
    logic [5:0]     r_cnt;
    logic           r_done;

    logic [255:0]   w_cv;
    logic [255:0]   w_work;
    logic [255:0]   w_sum;
    logic [31:0]    w_t1, w_t2, w_wnew;
    logic [31:0]    w_bs0, w_bs1, w_ch, w_maj, w_ss0, w_ss1;

    // Big sigmas on a/e, choose/majority, small sigmas for the schedule.
    assign w_bs0 = {r_a[1:0], r_a[31:2]} ^ {r_a[12:0], r_a[31:13]}
                 ^ {r_a[21:0], r_a[31:22]};
    assign w_bs1 = {r_e[5:0], r_e[31:6]} ^ {r_e[10:0], r_e[31:11]}
                 ^ {r_e[24:0], r_e[31:25]};
    assign w_ch  = (r_e & r_f) ^ (~r_e & r_g);
    assign w_maj = (r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c);
    assign w_ss0 = {r_w[1][6:0], r_w[1][31:7]}
                 ^ {r_w[1][17:0], r_w[1][31:18]}
                 ^ {3'b0, r_w[1][31:3]};
    assign w_ss1 = {r_w[14][16:0], r_w[14][31:17]}
                 ^ {r_w[14][18:0], r_w[14][31:19]}
                 ^ {10'b0, r_w[14][31:10]};

    assign w_t1   = r_h + w_bs1 + w_ch + k_in + r_w[0];
    assign w_t2   = w_bs0 + w_maj;
    // Window holds W[t..t+15]; this is W[t+16].
    assign w_wnew = w_ss1 + r_w[9] + w_ss0 + r_w[0];

    assign w_cv   = first ? IV : r_digest;
    assign w_work = {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h};

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 8; i++) begin
            w_sum[255-32*i -: 32] = r_hv[255-32*i -: 32]
                                  + w_work[255-32*i -: 32];
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = ROUND;
            ROUND:   if (r_cnt == 6'd63) w_next = FINAL;
            FINAL:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_w[i] <= '0;
            {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= '0;
            r_hv     <= '0;
            r_digest <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 16; i++)
                            r_w[i] <= block[511-32*i -: 32];
                        r_hv <= w_cv;
                        {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= w_cv;
                        r_cnt <= '0;
                    end
                end
                ROUND: begin
                    for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
                    r_w[15] <= w_wnew;
                    r_h <= r_g;
                    r_g <= r_f;
                    r_f <= r_e;
                    r_e <= r_d + w_t1;
                    r_d <= r_c;
                    r_c <= r_b;
                    r_b <= r_a;
                    r_a <= w_t1 + w_t2;
                    r_cnt <= r_cnt + 6'd1;
                end
                FINAL: begin
                    r_digest <= w_sum;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign round_o = (r_state == ROUND) ? r_cnt : 6'd0;
    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign digest  = r_digest;

endmodule

// File: tb/tb_sha256_compress.sv
// Directed-vector bench for sha256_compress with an attached K ROM.
// Covers reset, known digests, chaining, abort and ignored starts.
module tb_sha256_compress;

    localparam logic [0:63][31:0] KT = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h18};
    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B_TWO1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B_TWO2  = {480'h0, 32'h1c0};

`ifdef SHA224_EN
    localparam logic [255:0] D_ABC = {
        224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7,
        32'h0};
    localparam logic [255:0] MSK = {224'hffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff, 32'h0};
`else
    localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] MSK = {256{1'b1}};
`endif
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         first;
    logic [511:0] block;
    logic [31:0]  k_in;
    logic [5:0]   round_o;
    logic         busy;
    logic         done;
    logic [255:0] digest;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign k_in = KT[round_o];

    sha256_compress dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .first   (first),
        .block   (block),
        .k_in    (k_in),
        .round_o (round_o),
        .busy    (busy),
        .done    (done),
        .digest  (digest)
    );

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the start edge.
    task automatic kick(input logic [511:0] b, input logic f);
        start = 1'b1;
        block = b;
        first = f;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ndone;
        int seq_err;
        int busy_mid;
        logic [255:0] held;

        rst   = 1'b1;
        start = 1'b0;
        first = 1'b0;
        block = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   256'(busy),    256'(0));
        chk("rst_done",   256'(done),    256'(0));
        chk("rst_round",  256'(round_o), 256'(0));
        chk("rst_digest", digest,        256'(0));
        rst = 1'b0;
        @(negedge clk);

        kick(B_ABC, 1'b1);
        chk("abc_busy", 256'(busy), 256'(1));
        wait_done(lat);
        chk("abc_lat", 256'(lat), 256'(65));
        chk("abc_digest", digest & MSK, D_ABC);
        held = digest;
        repeat (5) @(negedge clk);
        chk("abc_held", digest, held);
        chk("abc_idle", 256'(busy), 256'(0));

`ifndef SHA224_EN
        kick(B_EMPTY, 1'b1);
        wait_done(lat);
        chk("empty_lat", 256'(lat), 256'(65));
        chk("empty_digest", digest, D_EMPTY);
        @(negedge clk);

        kick(B_TWO1, 1'b1);
        wait_done(lat);
        chk("two1_lat", 256'(lat), 256'(65));
        kick(B_TWO2, 1'b0);
        wait_done(lat);
        chk("two2_lat", 256'(lat), 256'(65));
        chk("two_digest", digest, D_TWO);
        @(negedge clk);
`endif

        kick(B_ABC, 1'b1);
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy",   256'(busy),    256'(0));
        chk("abort_digest", digest,        256'(0));
        chk("abort_round",  256'(round_o), 256'(0));
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_nodone", 256'(ndone), 256'(0));

        kick(B_ABC, 1'b1);
        block = ~B_ABC;
        first = 1'b0;
        ndone = 0;
        seq_err = 0;
        busy_mid = 0;
        for (int i = 0; i < 140; i++) begin
            if (i < 64 && round_o != 6'(i)) seq_err++;
            if (i == 64 && round_o != 6'd0) seq_err++;
            if (i == 10) busy_mid = int'(busy);
            if (done) ndone++;
            start = (i == 10 || i == 64);
            @(negedge clk);
        end
        start = 1'b0;
        chk("ign_seq",    256'(seq_err),  256'(0));
        chk("ign_busy",   256'(busy_mid), 256'(1));
        chk("ign_ndone",  256'(ndone),    256'(1));
        chk("ign_digest", digest & MSK,   D_ABC);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
